// File: rtl/fast_pkg.sv
// Shared types for the FAST front end: arbiter state encoding and the
// coordinate-width rule used by every block that carries an (x, y) address.
package fast_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Width wide enough to hold 0..max_v inclusive, so a full frame size fits.
  function automatic int coord_w(input int max_v);
    return $clog2(max_v) + 1;
  endfunction

endpackage

// File: rtl/raster_tracker.sv
// Tracks where the next in-order write must land and how many rows are
// complete; row_complete_o flags the write that finishes the current row.
module raster_tracker
  import fast_pkg::*;
#(
  parameter int X_MAX = 10,
  parameter int Y_MAX = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    adv_i,
  input  logic [$clog2(X_MAX):0]  max_x_i,
  output logic [$clog2(X_MAX):0]  ex_o,
  output logic [$clog2(Y_MAX):0]  ey_o,
  output logic [$clog2(Y_MAX):0]  rows_done_o,
  output logic                    row_complete_o
);

  localparam int XW = coord_w(X_MAX);
  localparam int YW = coord_w(Y_MAX);

  logic [XW-1:0] ex_q, ex_d;
  logic [YW-1:0] ey_q, ey_d;
  logic [YW-1:0] rows_q, rows_d;
  logic          last_col;

  assign last_col       = (ex_q == max_x_i - XW'(1));
  assign row_complete_o = adv_i && last_col;

  always_comb begin
    ex_d   = ex_q;
    ey_d   = ey_q;
    rows_d = rows_q;
    if (clear_i) begin
      ex_d   = '0;
      ey_d   = '0;
      rows_d = '0;
    end else if (adv_i) begin
      if (last_col) begin
        ex_d   = '0;
        ey_d   = ey_q + YW'(1);
        rows_d = rows_q + YW'(1);
      end else begin
        ex_d = ex_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      ey_q   <= '0;
      rows_q <= '0;
    end else begin
      ex_q   <= ex_d;
      ey_q   <= ey_d;
      rows_q <= rows_d;
    end
  end

  assign ex_o        = ex_q;
  assign ey_o        = ey_q;
  assign rows_done_o = rows_q;

endmodule

// File: rtl/image_sram_arbiter.sv
// Shares the single-port intermediate image SRAM between the in-order blur
// writer and the FAST reader, keeping the reader ROW_LEAD rows behind.
module image_sram_arbiter
  import fast_pkg::*;
#(
  parameter int X_MAX       = 10,
  parameter int Y_MAX       = 10,
  parameter int PIXEL_DEPTH = 8,
  parameter int ROW_LEAD    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [$clog2(X_MAX):0]  max_x,
  input  logic [$clog2(Y_MAX):0]  max_y,
  input  logic                    wr_req,
  input  logic [$clog2(X_MAX):0]  wr_x,
  input  logic [$clog2(Y_MAX):0]  wr_y,
  input  logic [PIXEL_DEPTH-1:0]  wr_data,
  output logic                    wr_gnt,
  input  logic                    rd_req,
  input  logic [$clog2(X_MAX):0]  rd_x,
  input  logic [$clog2(Y_MAX):0]  rd_y,
  output logic                    rd_gnt,
  output logic                    rd_valid,
  output logic [PIXEL_DEPTH-1:0]  rd_data,
  output logic [$clog2(X_MAX):0]  sram_x,
  output logic [$clog2(Y_MAX):0]  sram_y,
  output logic                    sram_wen,
  output logic                    sram_ren,
  output logic [PIXEL_DEPTH-1:0]  sram_wdat,
  input  logic [PIXEL_DEPTH-1:0]  sram_rdat,
  output logic [$clog2(Y_MAX):0]  rows_done,
  output logic                    wr_err,
  output logic                    frame_done
);

  localparam int XW  = coord_w(X_MAX);
  localparam int YW  = coord_w(Y_MAX);
  localparam int YW1 = YW + 1;

  arb_state_t    state_q, state_d;
  logic [XW-1:0] max_x_q;
  logic [YW-1:0] max_y_q;
  logic          last_rd_q;
  logic          wr_err_q;
  logic          rd_valid_q;

  logic [XW-1:0] ex;
  logic [YW-1:0] ey;
  logic [YW-1:0] rows_w;
  logic          row_complete;

  logic          wr_active;
  logic          wr_match;
  logic          wr_elig;
  logic          wr_mis;
  logic [YW1-1:0] rd_lead_row;
  logic          rd_lead_ok;
  logic          rd_elig;
  logic          rd_last_pix;

  raster_tracker #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_tracker (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (frame_start),
    .adv_i          (wr_gnt),
    .max_x_i        (max_x_q),
    .ex_o           (ex),
    .ey_o           (ey),
    .rows_done_o    (rows_w),
    .row_complete_o (row_complete)
  );

  assign wr_active = (state_q == ACTIVE) && wr_req;
  assign wr_match  = (wr_x == ex) && (wr_y == ey);
  assign wr_elig   = wr_active && wr_match;
  assign wr_mis    = wr_active && !wr_match;

  // One extra bit so rd_y + ROW_LEAD cannot wrap near the bottom of the frame.
  assign rd_lead_row = {1'b0, rd_y} + YW1'(ROW_LEAD);
  assign rd_lead_ok  = (rd_lead_row < {1'b0, rows_w}) || (rows_w == max_y_q);
  assign rd_elig     = rd_req && ((state_q == ACTIVE) || (state_q == DRAIN)) &&
                       (rd_x < max_x_q) && (rd_y < max_y_q) && rd_lead_ok;

  // Writer wins a tie only if the reader had the previous grant.
  assign wr_gnt = wr_elig && (!rd_elig || last_rd_q);
  assign rd_gnt = rd_elig && !wr_gnt;

  assign rd_last_pix = (rd_x == max_x_q - XW'(1)) && (rd_y == max_y_q - YW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE:  if (row_complete && (ey == max_y_q - YW'(1))) state_d = DRAIN;
      DRAIN:   if (rd_gnt && rd_last_pix) state_d = DONE;
      default: state_d = state_q;
    endcase
    if (frame_start) state_d = ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      max_x_q    <= '0;
      max_y_q    <= '0;
      last_rd_q  <= 1'b1;
      wr_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_gnt;
      if (frame_start) begin
        max_x_q <= max_x;
        max_y_q <= max_y;
      end
      if (wr_gnt)      last_rd_q <= 1'b0;
      else if (rd_gnt) last_rd_q <= 1'b1;
      if (frame_start) wr_err_q <= 1'b0;
      else if (wr_mis) wr_err_q <= 1'b1;
    end
  end

  assign sram_wen   = wr_gnt;
  assign sram_ren   = rd_gnt;
  assign sram_x     = wr_gnt ? wr_x : (rd_gnt ? rd_x : '0);
  assign sram_y     = wr_gnt ? wr_y : (rd_gnt ? rd_y : '0);
  assign sram_wdat  = wr_gnt ? wr_data : '0;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_valid_q ? sram_rdat : '0;
  assign rows_done  = rows_w;
  assign wr_err     = wr_err_q;
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_image_sram_arbiter.sv
// Self-checking bench for image_sram_arbiter with a behavioural SRAM and a
// read scoreboard keyed on rd_gnt / rd_valid.
module tb_image_sram_arbiter;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst, frame_start;
  logic [CW-1:0] max_x, max_y;
  logic          wr_req, rd_req;
  logic [CW-1:0] wr_x, wr_y, rd_x, rd_y;
  logic [7:0]    wr_data;
  logic          wr_gnt, rd_gnt, rd_valid;
  logic [7:0]    rd_data;
  logic [CW-1:0] sram_x, sram_y;
  logic          sram_wen, sram_ren;
  logic [7:0]    sram_wdat, sram_rdat;
  logic [CW-1:0] rows_done;
  logic          wr_err, frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int w93_cyc = -1;
  int first_rd_cyc = -1;
  bit trk_en = 1'b0;
  bit log_en = 1'b0;
  int arb_log[$];
  int sb[$];
  logic [7:0] mem [32][32];

  always #5 clk = ~clk;

  image_sram_arbiter #(
    .X_MAX(10), .Y_MAX(10), .PIXEL_DEPTH(8), .ROW_LEAD(3)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .max_x(max_x), .max_y(max_y),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .sram_x(sram_x), .sram_y(sram_y), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_wdat(sram_wdat), .sram_rdat(sram_rdat),
    .rows_done(rows_done), .wr_err(wr_err), .frame_done(frame_done)
  );

  initial sram_rdat = '0;
  always @(posedge clk) begin
    if (sram_wen) mem[sram_y][sram_x] <= sram_wdat;
    if (sram_ren) sram_rdat <= mem[sram_y][sram_x];
  end

  function automatic int pix(input int x, input int y);
    return (y * 16 + x + 53) % 256;
  endfunction

  function automatic void chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rd_valid) begin
      if (sb.size() == 0) chk("rd_valid_unexpected", 1, 0);
      else chk("rd_data", int'(rd_data), sb.pop_front());
    end
    if (rd_gnt) sb.push_back(pix(int'(rd_x), int'(rd_y)));
    if (trk_en && wr_gnt && wr_x == 5'd9 && wr_y == 5'd3) w93_cyc = cyc;
    if (trk_en && rd_gnt && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (log_en && (wr_gnt || rd_gnt)) arb_log.push_back((wr_gnt ? 1 : 0) + (rd_gnt ? 2 : 0));
  end

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wr_one(input int x, input int y);
    int n = 0;
    wr_req = 1'b1; wr_x = CW'(x); wr_y = CW'(y); wr_data = 8'(pix(x, y));
    @(negedge clk);
    while (!wr_gnt && n < 20) begin @(negedge clk); n++; end
    chk("wr_gnt", int'(wr_gnt), 1);
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic rd_one(input int x, input int y, input int limit);
    int n = 0;
    rd_req = 1'b1; rd_x = CW'(x); rd_y = CW'(y);
    @(negedge clk);
    while (!rd_gnt && n < limit) begin @(negedge clk); n++; end
    chk("rd_gnt", int'(rd_gnt), 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; max_x = 5'd10; max_y = 5'd10;
    wr_req = 1'b1; rd_req = 1'b1; wr_x = '0; wr_y = '0; rd_x = '0; rd_y = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // IDLE with both requesters asserted
    repeat (2) begin
      @(negedge clk);
      chk("idle_wr_gnt", int'(wr_gnt), 0);
      chk("idle_rd_gnt", int'(rd_gnt), 0);
      chk("idle_sram_wen", int'(sram_wen), 0);
      chk("idle_sram_ren", int'(sram_ren), 0);
      chk("idle_sram_x", int'(sram_x), 0);
      chk("idle_rd_valid", int'(rd_valid), 0);
      chk("idle_rd_data", int'(rd_data), 0);
      chk("idle_rows_done", int'(rows_done), 0);
      chk("idle_wr_err", int'(wr_err), 0);
      chk("idle_frame_done", int'(frame_done), 0);
    end
    @(posedge clk); #1;
    wr_req = 1'b0; rd_req = 1'b0;

    // Frame A: full raster fill, then drain reads
    pulse_start();
    chk("a_rows_start", int'(rows_done), 0);
    for (int y = 0; y < 10; y++) begin
      for (int x = 0; x < 10; x++) wr_one(x, y);
      chk("a_rows_done", int'(rows_done), y + 1);
    end
    chk("a_wr_err", int'(wr_err), 0);
    wr_req = 1'b1; wr_x = '0; wr_y = '0;
    @(negedge clk);
    chk("drain_wr_gnt", int'(wr_gnt), 0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    rd_one(0, 0, 5);
    chk("drain_frame_done", int'(frame_done), 0);
    rd_one(9, 9, 5);
    chk("done_frame_done", int'(frame_done), 1);
    repeat (2) @(posedge clk); #1;

    // Frame B: lead gating
    w93_cyc = -1; first_rd_cyc = -1; trk_en = 1'b1;
    pulse_start();
    chk("b_frame_done", int'(frame_done), 0);
    chk("b_rows_start", int'(rows_done), 0);
    fork
      begin
        rd_one(0, 0, 200);
        chk("b_rows_at_rd", int'(rows_done), 4);
      end
      begin
        for (int y = 0; y < 4; y++)
          for (int x = 0; x < 10; x++) wr_one(x, y);
      end
    join
    trk_en = 1'b0;
    chk("b_w93_seen", int'(w93_cyc >= 0), 1);
    chk("b_first_rd_lag", first_rd_cyc - w93_cyc, 1);

    // Contention: last grant was the read, so the writer goes first
    log_en = 1'b1;
    fork
      begin for (int i = 0; i < 3; i++) wr_one(i, 4); end
      begin for (int i = 1; i < 4; i++) rd_one(i, 0, 20); end
    join
    log_en = 1'b0;
    chk("arb_cnt", arb_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("arb_seq", (i < arb_log.size()) ? arb_log[i] : 0, (i % 2 == 0) ? 1 : 2);

    for (int x = 3; x < 10; x++) wr_one(x, 4);
    chk("b_rows_5", int'(rows_done), 5);

    // Abort mid-frame, then an out-of-order write
    pulse_start();
    chk("abort_rows_done", int'(rows_done), 0);
    for (int x = 0; x < 4; x++) wr_one(x, 0);
    wr_req = 1'b1; wr_x = 5'd5; wr_y = 5'd0; wr_data = 8'(pix(5, 0));
    repeat (2) begin
      @(negedge clk);
      chk("bad_wr_gnt", int'(wr_gnt), 0);
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
    chk("wr_err_set", int'(wr_err), 1);
    wr_one(4, 0);
    chk("wr_err_sticky", int'(wr_err), 1);
    pulse_start();
    chk("wr_err_cleared", int'(wr_err), 0);

    // Reset mid-frame
    wr_one(0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_rows_done", int'(rows_done), 0);
    wr_req = 1'b1; wr_x = '0; wr_y = '0;
    @(negedge clk);
    chk("rst_wr_gnt", int'(wr_gnt), 0);
    @(posedge clk); #1;
    wr_req = 1'b0;

    repeat (2) @(posedge clk); #1;
    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/image_sram_arbiter.md
# image_sram_arbiter

Shares the single-port intermediate image SRAM (Gaussian output / FAST input) between the Gaussian blur writer and the FAST corner reader, so both stages run concurrently on one frame. Writes arrive in raster order. A read of row y is granted only once row y+ROW_LEAD, or the final row, has been fully written. The block also checks write ordering and reports frame completion to the top-level sequencer.

## Interface
- X_MAX, 10, maximum image width; coordinates are $clog2(X_MAX)+1 bits wide.
- Y_MAX, 10, maximum image height; the y coordinate uses the same width rule.
- PIXEL_DEPTH, 8, pixel width in bits.
- ROW_LEAD, 3, rows the writer must stay ahead of the reader (FAST circle radius).
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- frame_start  input  1  one-cycle pulse; latches max_x/max_y and starts a frame.
- max_x, max_y  input  $clog2(X_MAX)+1  active frame size, 1..X_MAX and 1..Y_MAX.
- wr_req  input  1  Gaussian write request.
- wr_x, wr_y  input  coord  write address.
- wr_data  input  PIXEL_DEPTH  write data.
- wr_gnt  output  1  write accepted this cycle.
- rd_req  input  1  FAST read request.
- rd_x, rd_y  input  coord  read address.
- rd_gnt  output  1  read accepted this cycle.
- rd_valid  output  1  rd_data valid; asserts 1 cycle after rd_gnt.
- rd_data  output  PIXEL_DEPTH  read pixel.
- sram_x, sram_y  output  coord  SRAM address.
- sram_wen, sram_ren  output  1  SRAM strobes.
- sram_wdat  output  PIXEL_DEPTH  SRAM write data.
- sram_rdat  input  PIXEL_DEPTH  SRAM read data, 1-cycle latency.
- rows_done  output  coord  count of fully written rows.
- wr_err  output  1  sticky out-of-order write flag; cleared by frame_start.
- frame_done  output  1  level; frame fully written and fully read.

## Operation
- States:
  - IDLE: no grants. frame_start moves to ACTIVE.
  - ACTIVE: the writer and reader share the SRAM. Moves to DRAIN when rows_done reaches max_y.
  - DRAIN: reads only. Moves to DONE on the grant of read (max_x-1, max_y-1).
  - DONE: frame_done = 1. frame_start moves to ACTIVE.
- frame_start in any state: clears the expected-write counters (ex, ey), rows_done and wr_err, and enters ACTIVE. An in-flight rd_valid still completes.
- Write eligibility: ACTIVE, and (wr_x, wr_y) == (ex, ey).
  - A request that is not eligible is never granted.
  - An address mismatch sets wr_err.
  - Each granted write advances ex. When ex == max_x-1, ex wraps to 0 and ey and rows_done increment.
- Read eligibility: ACTIVE or DRAIN, rd_x < max_x, rd_y < max_y, and (rd_y + ROW_LEAD < rows_done or rows_done == max_y). The compare is done at coord+1 width so it cannot overflow.
- Arbitration when both are eligible: round-robin on a last_grant bit, reset to "read", so the writer wins first. A lone eligible requester always wins. At most one grant per cycle.
- SRAM mux: combinational from the granted requester. sram_wen = wr_gnt, sram_ren = rd_gnt. rd_data = sram_rdat.

## Timing
- Grants are combinational in the request cycle. Requesters hold req and address until granted.
- Counters, last_grant and state update on the clk edge following a grant.
- The write completing row k makes reads of row k-ROW_LEAD eligible in the next cycle, not the same one.
- rd_valid is registered: high exactly 1 cycle after rd_gnt, including across frame_start.
- Reset values: state IDLE; all grants, strobes, rd_valid, wr_err, frame_done = 0; rows_done = 0; addresses and data = 0.
- rst mid-frame: all outputs return to reset values on the next edge, and any pending rd_valid is dropped.
- Read throughput is one pixel per cycle when the writer is idle. Under contention it is 1/2.

## Structure
- Add to fast_pkg:
  - the arb_state_t enum {IDLE, ACTIVE, DRAIN, DONE};
  - a coordinate-width localparam helper.
- One natural sub-module, raster_tracker. It holds ex, ey and rows_done, and produces the expected address plus a row_complete pulse.
- Arbitration, the state machine and the SRAM mux live in the top module.

## Test plan
All scenarios use max_x = max_y = 10 and ROW_LEAD = 3.
- Reset then idle: hold wr_req and rd_req high in IDLE -> no grants; all outputs 0.
- Raster fill with no reads: frame_start, then 100 in-order writes -> 100 wr_gnt; rows_done steps 0..10; state DRAIN; wr_err = 0.
- Lead gating: the reader requests (0,0) from frame_start.
  - rd_gnt stays 0 while rows_done ≤ 3.
  - The first rd_gnt comes the cycle after the write of (9,3).
  - rd_valid follows one cycle later, carrying the pixel written at (0,0).
- Contention: both requesters held eligible for 6 cycles -> grants alternate W,R,W,R,W,R.
- Order error: a write to (5,0) when (4,0) is expected -> no wr_gnt; wr_err = 1; ex stays 4. The next frame_start clears wr_err.
- Completion and abort:
  - Read (9,9) in DRAIN -> frame_done = 1 the next cycle.
  - frame_start mid-ACTIVE at rows_done = 5 -> rows_done = 0, and a write to (0,0) is granted.
